// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - memory-to-writeback handshake and instruction bus
interface wb_stage_if #(
  parameter int BUS_W = 199
);
  logic             ms2ws_valid;
  logic             ws_allowin;
  logic [BUS_W-1:0] ms2ws_bus;

  modport master (output ms2ws_valid, output ms2ws_bus, input ws_allowin);
  modport slave  (input ms2ws_valid, input ms2ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: regfile/CSR commit, exception flush, trace (option WB_RETIRE_CNT_EN)
module wb_stage #(
  parameter int EXC_W = 97,
  parameter int BUS_W = 199
) (
  input  logic              clk,
  input  logic              reset,
  wb_stage_if.slave         ms_if,
  input  logic [31:0]       csr_rvalue,
  output logic              csr_re,
  output logic              csr_we,
  output logic [13:0]       csr_num,
  output logic [31:0]       csr_wmask,
  output logic [31:0]       csr_wvalue,
  output logic              wb_ex,
  output logic              ertn_flush,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic [31:0]       wb_pc,
  output logic [31:0]       wb_vaddr,
  output logic              ws_reflush,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic [37:0]       wb_forward_zip,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]       retire_cnt,
  output logic [31:0]       ex_cnt,
`endif
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
);

  logic             ws_valid;
  logic [BUS_W-1:0] bus_reg;

  logic [31:0]      pc;
  logic             gr_we;
  logic [4:0]       dest;
  logic [31:0]      final_result;
  logic [31:0]      rkd_value;
  logic [EXC_W-1:0] exc;

  logic [31:0]      wrong_addr;
  logic             csr_we_field;
  logic [31:0]      wmask_field;
  logic [13:0]      num_field;
  logic             ertn_field;
  logic             ex_field;
  logic [8:0]       esubcode_field;
  logic [5:0]       ecode_field;
  logic             csr_re_field;

  logic             commit_ex;
  logic             commit_ertn;

  assign ms_if.ws_allowin = 1'b1;

  assign {pc, gr_we, dest, final_result, rkd_value, exc} = bus_reg;
  assign {wrong_addr, csr_we_field, wmask_field, num_field, ertn_field,
          ex_field, esubcode_field, ecode_field, csr_re_field} = exc;

  // A flushing commit kills whatever the memory stage offers in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
    end else if (ws_reflush) begin
      ws_valid <= 1'b0;
    end else begin
      ws_valid <= ms_if.ms2ws_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (ms_if.ms2ws_valid && ms_if.ws_allowin && !ws_reflush) begin
      bus_reg <= ms_if.ms2ws_bus;
    end
  end

  assign commit_ex   = ws_valid & ex_field;
  assign commit_ertn = ws_valid & ertn_field & ~ex_field;

  assign wb_ex       = commit_ex;
  assign ertn_flush  = commit_ertn;
  assign ws_reflush  = commit_ex | commit_ertn;

  assign wb_ecode    = ecode_field;
  assign wb_esubcode = esubcode_field;
  assign wb_pc       = pc;
  assign wb_vaddr    = wrong_addr;

  assign csr_we      = ws_valid & csr_we_field & ~ex_field;
  assign csr_re      = ws_valid & csr_re_field;
  assign csr_num     = num_field;
  assign csr_wmask   = wmask_field;
  assign csr_wvalue  = rkd_value;

  assign rf_we       = ws_valid & gr_we & ~ex_field;
  assign rf_waddr    = dest;
  assign rf_wdata    = csr_re_field ? csr_rvalue : final_result;

  assign wb_forward_zip    = {rf_we, rf_waddr, rf_wdata};

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

`ifdef WB_RETIRE_CNT_EN
  logic flush_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_d    <= 1'b0;
      retire_cnt <= 64'd0;
      ex_cnt     <= 32'd0;
    end else begin
      flush_d <= ws_reflush;
      // ertn is a normal retirement; only exceptions are excluded.
      if (ws_valid && !commit_ex) begin
        retire_cnt <= retire_cnt + 64'd1;
      end
      if (commit_ex && ex_cnt != 32'hFFFF_FFFF) begin
        ex_cnt <= ex_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
